// File: rtl/fetch_issue_queue.sv
// Dual-issue fetch queue feeding the IF/ID decode slot pair.
// Ports: fetch push (2 wide), stall/conflict/flush retire control,
// two issue slots with inst/pc/rs fields, fetch_ready and count.
module fetch_issue_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] NOP_INST = 'h13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_valid_0,
  input  logic            fetch_valid_1,
  input  logic [XLEN-1:0] fetch_inst_0,
  input  logic [XLEN-1:0] fetch_inst_1,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            fetch_ready,
  input  logic            stall,
  input  logic            dual_issue_conflict,
  input  logic            flush,
  output logic            if_id_valid_0,
  output logic            if_id_valid_1,
  output logic [XLEN-1:0] if_id_inst_0,
  output logic [XLEN-1:0] if_id_inst_1,
  output logic [XLEN-1:0] if_id_pc_0,
  output logic [XLEN-1:0] if_id_pc_1,
  output logic [4:0]      if_id_rs1_0,
  output logic [4:0]      if_id_rs2_0,
  output logic [4:0]      if_id_rs1_1,
  output logic [4:0]      if_id_rs2_1,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] inst_q [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr_1;
  logic [PW-1:0] wr_ptr_1;
  logic [CW-1:0] count_q;

  logic [1:0] push_n;
  logic [1:0] pop_n;

  logic [XLEN-1:0] raw_0;
  logic [XLEN-1:0] raw_1;

  assign rd_ptr_1 = rd_ptr + PW'(1);
  assign wr_ptr_1 = wr_ptr + PW'(1);

  assign count         = count_q;
  assign if_id_valid_0 = (count_q != '0);
  assign if_id_valid_1 = (count_q >= CW'(2));

  // Only registered count: no same-cycle pop credit, so no overflow.
  assign fetch_ready = (count_q <= CW'(DEPTH - 2));

  always_comb begin
    push_n = 2'd0;
    if (fetch_valid_0 && fetch_ready)
      push_n = fetch_valid_1 ? 2'd2 : 2'd1;
  end

  always_comb begin
    pop_n = 2'd0;
    if (!flush && !stall)
      pop_n = {1'b0, if_id_valid_0}
            + {1'b0, if_id_valid_1 & ~dual_issue_conflict};
  end

  assign raw_0 = inst_q[rd_ptr];
  assign raw_1 = inst_q[rd_ptr_1];

  assign if_id_inst_0 = if_id_valid_0 ? raw_0 : NOP_INST;
  assign if_id_inst_1 = if_id_valid_1 ? raw_1 : NOP_INST;
  assign if_id_pc_0   = if_id_valid_0 ? pc_q[rd_ptr]   : '0;
  assign if_id_pc_1   = if_id_valid_1 ? pc_q[rd_ptr_1] : '0;

  assign if_id_rs1_0 = if_id_valid_0 ? raw_0[19:15] : '0;
  assign if_id_rs2_0 = if_id_valid_0 ? raw_0[24:20] : '0;
  assign if_id_rs1_1 = if_id_valid_1 ? raw_1[19:15] : '0;
  assign if_id_rs2_1 = if_id_valid_1 ? raw_1[24:20] : '0;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!flush && push_n != 2'd0) begin
      inst_q[wr_ptr] <= fetch_inst_0;
      pc_q[wr_ptr]   <= fetch_pc;
    end
    if (!flush && push_n == 2'd2) begin
      inst_q[wr_ptr_1] <= fetch_inst_1;
      pc_q[wr_ptr_1]   <= fetch_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      rd_ptr  <= rd_ptr + PW'(pop_n);
      wr_ptr  <= wr_ptr + PW'(push_n);
      count_q <= count_q + CW'(push_n) - CW'(pop_n);
    end
  end

endmodule

// File: tb/tb_fetch_issue_queue.sv
// Directed self-checking bench for fetch_issue_queue.
// Each task drives one scenario and checks its own results.
module tb_fetch_issue_queue;

  localparam int DEPTH = 8;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fetch_valid_0 = 1'b0;
  logic fetch_valid_1 = 1'b0;
  logic [31:0] fetch_inst_0 = '0;
  logic [31:0] fetch_inst_1 = '0;
  logic [31:0] fetch_pc = '0;
  logic fetch_ready;
  logic stall = 1'b0;
  logic dual_issue_conflict = 1'b0;
  logic flush = 1'b0;
  logic if_id_valid_0, if_id_valid_1;
  logic [31:0] if_id_inst_0, if_id_inst_1;
  logic [31:0] if_id_pc_0, if_id_pc_1;
  logic [4:0] if_id_rs1_0, if_id_rs2_0;
  logic [4:0] if_id_rs1_1, if_id_rs2_1;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  fetch_issue_queue #(
    .DEPTH(DEPTH), .XLEN(XLEN), .NOP_INST(NOP)
  ) dut (
    .clk(clk), .rst(rst),
    .fetch_valid_0(fetch_valid_0),
    .fetch_valid_1(fetch_valid_1),
    .fetch_inst_0(fetch_inst_0),
    .fetch_inst_1(fetch_inst_1),
    .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready),
    .stall(stall),
    .dual_issue_conflict(dual_issue_conflict),
    .flush(flush),
    .if_id_valid_0(if_id_valid_0),
    .if_id_valid_1(if_id_valid_1),
    .if_id_inst_0(if_id_inst_0),
    .if_id_inst_1(if_id_inst_1),
    .if_id_pc_0(if_id_pc_0),
    .if_id_pc_1(if_id_pc_1),
    .if_id_rs1_0(if_id_rs1_0),
    .if_id_rs2_0(if_id_rs2_0),
    .if_id_rs1_1(if_id_rs1_1),
    .if_id_rs2_1(if_id_rs2_1),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_valid_0 = 1'b0;
    fetch_valid_1 = 1'b0;
    stall = 1'b0;
    dual_issue_conflict = 1'b0;
    flush = 1'b0;
  endtask

  task automatic push2(input logic [31:0] pc,
                       input logic [31:0] i0,
                       input logic [31:0] i1);
    fetch_valid_0 = 1'b1;
    fetch_valid_1 = 1'b1;
    fetch_pc = pc;
    fetch_inst_0 = i0;
    fetch_inst_1 = i1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (if_id_valid_0 !== 1'b0 || if_id_valid_1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b%b exp 00",
               if_id_valid_0, if_id_valid_1);
    end
    checks++;
    if (fetch_ready !== 1'b1 || count !== 4'd0) begin
      errors++;
      $display("FAIL reset_ready_count: got %b/%0d exp 1/0",
               fetch_ready, count);
    end
    checks++;
    if (if_id_inst_0 !== NOP || if_id_pc_0 !== 32'h0
        || if_id_rs1_0 !== 5'd0 || if_id_inst_1 !== NOP) begin
      errors++;
      $display("FAIL reset_slots: got %h@%h exp %h@0",
               if_id_inst_0, if_id_pc_0, NOP);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
  endtask

  task automatic test_dual_push_pop();
    push2(32'h100, 32'h00500093, 32'h00a08113);
    tick();
    idle();
    checks++;
    if (if_id_valid_0 !== 1'b1 || if_id_valid_1 !== 1'b1
        || count !== 4'd2) begin
      errors++;
      $display("FAIL dual_valid: got %b%b cnt %0d exp 11 cnt 2",
               if_id_valid_0, if_id_valid_1, count);
    end
    checks++;
    if (if_id_pc_0 !== 32'h100 || if_id_pc_1 !== 32'h104) begin
      errors++;
      $display("FAIL dual_pc: got %h/%h exp 100/104",
               if_id_pc_0, if_id_pc_1);
    end
    checks++;
    if (if_id_inst_0 !== 32'h00500093
        || if_id_inst_1 !== 32'h00a08113) begin
      errors++;
      $display("FAIL dual_inst: got %h/%h exp 00500093/00a08113",
               if_id_inst_0, if_id_inst_1);
    end
    checks++;
    if (if_id_rs1_1 !== 5'd1 || if_id_rs2_1 !== 5'd10
        || if_id_rs1_0 !== 5'd0 || if_id_rs2_0 !== 5'd5) begin
      errors++;
      $display("FAIL dual_rs: got %0d,%0d,%0d,%0d exp 0,5,1,10",
               if_id_rs1_0, if_id_rs2_0, if_id_rs1_1, if_id_rs2_1);
    end
    tick();
    checks++;
    if (count !== 4'd0 || if_id_valid_0 !== 1'b0) begin
      errors++;
      $display("FAIL dual_drain: got cnt %0d v0 %b exp 0 0",
               count, if_id_valid_0);
    end
  endtask

  task automatic test_conflict_split();
    stall = 1'b1;
    push2(32'h100, 32'hA0000100, 32'hA0000104);
    tick();
    fetch_valid_1 = 1'b0;
    fetch_pc = 32'h108;
    fetch_inst_0 = 32'hA0000108;
    tick();
    idle();
    dual_issue_conflict = 1'b1;
    checks++;
    if (count !== 4'd3) begin
      errors++;
      $display("FAIL conflict_pre: got cnt %0d exp 3", count);
    end
    tick();
    dual_issue_conflict = 1'b0;
    checks++;
    if (count !== 4'd2) begin
      errors++;
      $display("FAIL conflict_cnt: got %0d exp 2", count);
    end
    checks++;
    if (if_id_pc_0 !== 32'h104 || if_id_pc_1 !== 32'h108
        || if_id_inst_0 !== 32'hA0000104) begin
      errors++;
      $display("FAIL conflict_slots: got %h/%h exp 104/108",
               if_id_pc_0, if_id_pc_1);
    end
    tick();
    checks++;
    if (count !== 4'd0) begin
      errors++;
      $display("FAIL conflict_drain: got %0d exp 0", count);
    end
  endtask

  task automatic test_fill_stall();
    logic [31:0] pc;
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pc = 32'h300 + 32'(k * 8);
      push2(pc, 32'hB0000000 | pc, 32'hB0000004 | pc);
      tick();
      checks++;
      if (count !== 4'(2 * (k + 1))) begin
        errors++;
        $display("FAIL fill_cnt%0d: got %0d exp %0d",
                 k, count, 2 * (k + 1));
      end
    end
    checks++;
    if (fetch_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_ready: got %b exp 0", fetch_ready);
    end
    push2(32'h900, 32'hDEAD0000, 32'hDEAD0004);
    tick();
    fetch_valid_0 = 1'b0;
    fetch_valid_1 = 1'b0;
    checks++;
    if (count !== 4'd8 || if_id_pc_0 !== 32'h300
        || if_id_inst_1 !== 32'hB0000304) begin
      errors++;
      $display("FAIL fill_hold: got cnt %0d pc %h exp 8 300",
               count, if_id_pc_0);
    end
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (if_id_pc_0 !== 32'h300 + 32'(k * 8)
          || if_id_inst_0 !== (32'hB0000300 + 32'(k * 8))) begin
        errors++;
        $display("FAIL fill_order%0d: got %h exp %h",
                 k, if_id_pc_0, 32'h300 + 32'(k * 8));
      end
      tick();
    end
    checks++;
    if (count !== 4'd0) begin
      errors++;
      $display("FAIL fill_drain: got %0d exp 0", count);
    end
  endtask

  task automatic test_flush_collision();
    stall = 1'b1;
    push2(32'h400, 32'h1, 32'h2);
    tick();
    push2(32'h408, 32'h3, 32'h4);
    tick();
    stall = 1'b0;
    flush = 1'b1;
    push2(32'h410, 32'h5, 32'h6);
    tick();
    idle();
    checks++;
    if (count !== 4'd0 || if_id_valid_0 !== 1'b0
        || fetch_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_state: got cnt %0d v0 %b exp 0 0",
               count, if_id_valid_0);
    end
    fetch_valid_0 = 1'b1;
    fetch_pc = 32'h500;
    fetch_inst_0 = 32'hC0000500;
    tick();
    idle();
    checks++;
    if (count !== 4'd1 || if_id_pc_0 !== 32'h500
        || if_id_valid_1 !== 1'b0) begin
      errors++;
      $display("FAIL flush_after: got cnt %0d pc %h exp 1 500",
               count, if_id_pc_0);
    end
    tick();
  endtask

  task automatic test_reset_midstream();
    stall = 1'b1;
    push2(32'h600, 32'h7, 32'h8);
    tick();
    push2(32'h608, 32'h9, 32'hA);
    tick();
    fetch_valid_1 = 1'b0;
    fetch_pc = 32'h610;
    tick();
    idle();
    checks++;
    if (count !== 4'd5) begin
      errors++;
      $display("FAIL mid_pre: got cnt %0d exp 5", count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (if_id_valid_0 !== 1'b0 || if_id_valid_1 !== 1'b0
        || fetch_ready !== 1'b1 || count !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset: got v %b%b rdy %b cnt %0d exp 00 1 0",
               if_id_valid_0, if_id_valid_1, fetch_ready, count);
    end
    #1 rst = 1'b0;
    tick();
    fetch_valid_0 = 1'b1;
    fetch_pc = 32'h200;
    fetch_inst_0 = 32'hE0000200;
    tick();
    idle();
    checks++;
    if (if_id_valid_0 !== 1'b1 || if_id_pc_0 !== 32'h200) begin
      errors++;
      $display("FAIL mid_first: got v0 %b pc %h exp 1 200",
               if_id_valid_0, if_id_pc_0);
    end
    tick();
  endtask

  task automatic test_wrap_ordering();
    logic [31:0] q[$];
    int pairs = 0;
    int retired = 0;
    int pops;
    int errs0 = errors;
    bit do_push;
    for (int cyc = 0; cyc < 1000 && retired < 80; cyc++) begin
      checks++;
      if (count !== 4'(q.size())) begin
        errors++;
        $display("FAIL wrap_cnt c%0d: got %0d exp %0d",
                 cyc, count, q.size());
      end
      if (q.size() >= 1) begin
        checks++;
        if (if_id_pc_0 !== q[0]
            || if_id_inst_0 !== (q[0] | 32'hA0000000)) begin
          errors++;
          $display("FAIL wrap_slot0 c%0d: got %h exp %h",
                   cyc, if_id_pc_0, q[0]);
        end
      end
      if (q.size() >= 2) begin
        checks++;
        if (if_id_pc_1 !== q[1]) begin
          errors++;
          $display("FAIL wrap_slot1 c%0d: got %h exp %h",
                   cyc, if_id_pc_1, q[1]);
        end
      end
      stall = ($urandom_range(0, 3) == 0);
      dual_issue_conflict = ($urandom_range(0, 2) == 0);
      do_push = (pairs < 40) && ($urandom_range(0, 3) != 0);
      fetch_valid_0 = do_push;
      fetch_valid_1 = do_push;
      fetch_pc = 32'(pairs * 8);
      fetch_inst_0 = fetch_pc | 32'hA0000000;
      fetch_inst_1 = (fetch_pc + 32'd4) | 32'hA0000000;
      pops = 0;
      if (!stall) begin
        if (q.size() >= 1) pops = 1;
        if (q.size() >= 2 && !dual_issue_conflict) pops = 2;
      end
      for (int p = 0; p < pops; p++) begin
        checks++;
        if (q[0] !== 32'(retired * 4)) begin
          errors++;
          $display("FAIL wrap_seq: got %h exp %h",
                   q[0], 32'(retired * 4));
        end
        void'(q.pop_front());
        retired++;
      end
      if (do_push && (count <= 4'(DEPTH - 2))) begin
        q.push_back(32'(pairs * 8));
        q.push_back(32'(pairs * 8 + 4));
        pairs++;
      end
      tick();
    end
    idle();
    checks++;
    if (retired != 80 || count !== 4'd0) begin
      errors++;
      $display("FAIL wrap_total: got %0d cnt %0d exp 80 0",
               retired, count);
    end
    if (errors != errs0)
      $display("wrap scenario saw %0d errors", errors - errs0);
  endtask

  initial begin
    test_reset();
    test_dual_push_pop();
    test_conflict_split();
    test_fill_stall();
    test_flush_collision();
    test_reset_midstream();
    test_wrap_ordering();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_issue_queue.md
# fetch_issue_queue

Dual-issue instruction queue between fetch and the IF/ID decode slot pair. It accepts up to two fetched instructions per cycle and presents the two oldest as issue slots 0/1 with register-source fields for the hazard unit. It retires 0, 1 or 2 entries per cycle depending on pipeline stall and the slot-0→slot-1 RAW conflict flag. A redirect flush empties it.

## Interface
- DEPTH, 8, number of entries; power of two, ≥4
- XLEN, 32, instruction and PC width
- NOP_INST, 32'h0000_0013, value driven on an invalid slot's instruction port
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- fetch_valid_0  in  1  fetch slot 0 valid
- fetch_valid_1  in  1  fetch slot 1 valid; honoured only with fetch_valid_0
- fetch_inst_0, fetch_inst_1  in  XLEN  fetched instructions
- fetch_pc  in  XLEN  PC of fetch slot 0; slot 1 PC = fetch_pc+4
- fetch_ready  out  1  ≥2 free entries; fetch may push this cycle
- stall  in  1  load-use stall from the hazard unit; no retire
- dual_issue_conflict  in  1  slot 1 depends on slot 0; retire slot 0 only
- flush  in  1  redirect; discard all contents
- if_id_valid_0, if_id_valid_1  out  1  issue slot valid
- if_id_inst_0, if_id_inst_1  out  XLEN  issue slot instruction
- if_id_pc_0, if_id_pc_1  out  XLEN  issue slot PC
- if_id_rs1_0, if_id_rs2_0, if_id_rs1_1, if_id_rs2_1  out  5  inst[19:15] / inst[24:20] of each slot; 0 when slot invalid
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Storage: DEPTH × {inst, pc} circular buffer. rd_ptr, wr_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH. Separate count register.
- Push: push_n = (fetch_valid_0 & fetch_ready) ? 1 + fetch_valid_1 : 0.
  - Slot 0 is written at wr_ptr with fetch_pc.
  - Slot 1 is written at wr_ptr+1 with fetch_pc+4.
  - fetch_valid_1 without fetch_valid_0 pushes nothing.
- Issue view: slot 0 = entry[rd_ptr], slot 1 = entry[rd_ptr+1].
  - if_id_valid_0 = count≥1; if_id_valid_1 = count≥2.
  - Invalid slot drives inst=NOP_INST, pc=0, rs fields=0.
- Retire: if flush or stall, pop_n=0. Otherwise pop_n = if_id_valid_0 + (if_id_valid_1 & ~dual_issue_conflict).
  - After a conflict pop of 1, the old slot 1 becomes slot 0 next cycle.
- Update: rd_ptr += pop_n, wr_ptr += push_n, count += push_n − pop_n.
- Flush has priority over push and pop. Next state: rd_ptr=wr_ptr=0, count=0. Same-cycle fetch data is dropped.
- fetch_ready = (DEPTH − count) ≥ 2, from the registered count only. There is no same-cycle pop credit, so overflow is impossible.
- Pop never exceeds count by construction. Underflow is impossible.
- Reset (async, any time, including mid-stream):
  - rd_ptr=wr_ptr=count=0.
  - Outputs immediately: if_id_valid_0/1=0, insts=NOP_INST, pcs=0, rs=0, fetch_ready=1, count=0.
  - Storage array is not reset.

## Timing
- Push→issue latency: 1 cycle. Data pushed at edge N is visible on the slot outputs after edge N. There is no combinational fetch→issue bypass.
- Issue outputs, fetch_ready and count are combinational from registers only. They have no dependence on stall, conflict or flush.
- Sustained throughput is 2 instr/cycle with no stall/conflict once count≥2.
- Stall holds slot outputs stable. Pushes continue while fetch_ready=1.
- Flush: outputs invalid in the cycle after the flush edge. A push in that next cycle is accepted normally.
- Simultaneous push 2 / pop 2 at count=DEPTH−2: legal; count is unchanged.

## Test plan
- Reset mid-stream: count=5, assert rst asynchronously between edges → valid_0/1=0, fetch_ready=1, count=0 immediately; after release, the first push of pc 0x200 appears as slot 0 one cycle later.
- Dual push/pop: empty queue, push inst 0x00500093/0x00a08113 at pc 0x100 → next cycle valid_0/1=1, pcs 0x100/0x104, rs1_1=1, rs2_1=10; no stall, no conflict → count=0 the following cycle.
- Conflict split: queue holds A@0x100, B@0x104, C@0x108, dual_issue_conflict=1 → pop 1, count 3→2; next cycle slot0=B@0x104, slot1=C@0x108.
- Fill under stall: DEPTH=8, stall=1, fetch pushes 2 every cycle → count 0,2,4,6,8; fetch_ready=0 at count 8; a push attempted then leaves count at 8 and entry contents unchanged.
- Flush collision: count=4 with push 2 and pop 2 in the same cycle as flush=1 → next cycle count=0, valid_0=0, pushed data never issued.
- Wrap ordering: 40 consecutive pairs with pcs incrementing by 8 and random stall/conflict/push gaps → retired PC sequence is strictly 0x0, 0x4, 0x8, … with no loss or duplication across pointer wrap.
